// File: rtl/object_plotter.sv
// Plots one object per request: erases the old rectangle, draws the new one, one pixel per clock.
// Build option: define OBJECT_PLOTTER_ERASE_EN to include the erase pass over the old rectangle.
module object_plotter #(
  parameter int unsigned MAXX          = 159,
  parameter int unsigned MAXY          = 119,
  parameter logic [2:0]  BG_COLOUR     = 3'b000,
  parameter logic [2:0]  BALL_COLOUR   = 3'b111,
  parameter logic [2:0]  PADDLE_COLOUR = 3'b010,
  parameter logic [2:0]  BLOCK_COLOUR  = 3'b100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       startPlot,
  input  logic [1:0] object,
  input  logic [7:0] newX,
  input  logic [6:0] newY,
  input  logic [7:0] oldX,
  input  logic [6:0] oldY,
  input  logic [7:0] sizeX,
  input  logic [6:0] sizeY,
  output logic       busy,
  output logic       done,
  output logic [7:0] vgaX,
  output logic [6:0] vgaY,
  output logic [2:0] colour,
  output logic       plot
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_ERASE,
    ST_DRAW,
    ST_DONE
  } state_t;

  localparam logic [8:0] LP_MAXX = 9'(MAXX);
  localparam logic [7:0] LP_MAXY = 8'(MAXY);

  state_t     r_state;
  state_t     w_next;

  logic [1:0] r_object;
  logic [7:0] r_newX;
  logic [6:0] r_newY;
  logic [7:0] r_sizeX;
  logic [6:0] r_sizeY;
  logic [7:0] r_col;
  logic [6:0] r_row;

  logic       r_busy;
  logic       r_done;
  logic [7:0] r_vgaX;
  logic [6:0] r_vgaY;
  logic [2:0] r_colour;
  logic       r_plot;

  logic [7:0] w_base_x;
  logic [6:0] w_base_y;
  logic [8:0] w_sum_x;
  logic [7:0] w_sum_y;
  logic [2:0] w_obj_colour;
  logic [2:0] w_pix_colour;
  logic       w_scan;
  logic       w_col_wrap;
  logic       w_last;
  logic       w_visible;
  logic       w_empty;

`ifdef OBJECT_PLOTTER_ERASE_EN
  logic [7:0] r_oldX;
  logic [6:0] r_oldY;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_oldX <= '0;
      r_oldY <= '0;
    end else if (r_state == ST_LATCH) begin
      r_oldX <= oldX;
      r_oldY <= oldY;
    end
  end

  assign w_base_x     = (r_state == ST_ERASE) ? r_oldX : r_newX;
  assign w_base_y     = (r_state == ST_ERASE) ? r_oldY : r_newY;
  assign w_pix_colour = (r_state == ST_ERASE) ? BG_COLOUR : w_obj_colour;
`else
  logic w_unused_old;
  assign w_unused_old = ^{oldX, oldY};

  assign w_base_x     = r_newX;
  assign w_base_y     = r_newY;
  assign w_pix_colour = w_obj_colour;
`endif

  always_comb begin
    w_obj_colour = BG_COLOUR;
    case (r_object)
      2'b00:   w_obj_colour = BALL_COLOUR;
      2'b01:   w_obj_colour = PADDLE_COLOUR;
      2'b10:   w_obj_colour = BLOCK_COLOUR;
      default: w_obj_colour = BG_COLOUR;
    endcase
  end

  // Sums are one bit wider than the coordinates so off-screen pixels clip instead of wrapping.
  assign w_sum_x    = {1'b0, w_base_x} + {1'b0, r_col};
  assign w_sum_y    = {1'b0, w_base_y} + {1'b0, r_row};
  assign w_visible  = (w_sum_x <= LP_MAXX) && (w_sum_y <= LP_MAXY);
  assign w_scan     = (r_state == ST_ERASE) || (r_state == ST_DRAW);
  assign w_col_wrap = (r_col == (r_sizeX - 8'd1));
  assign w_last     = w_col_wrap && (r_row == (r_sizeY - 7'd1));
  assign w_empty    = (object == 2'b11) || (sizeX == '0) || (sizeY == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (startPlot) w_next = ST_LATCH;
      ST_LATCH: begin
        if (w_empty) begin
          w_next = ST_DONE;
        end else begin
`ifdef OBJECT_PLOTTER_ERASE_EN
          w_next = ST_ERASE;
`else
          w_next = ST_DRAW;
`endif
        end
      end
      ST_ERASE: if (w_last) w_next = ST_DRAW;
      ST_DRAW:  if (w_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_object <= '0;
      r_newX   <= '0;
      r_newY   <= '0;
      r_sizeX  <= '0;
      r_sizeY  <= '0;
      r_col    <= '0;
      r_row    <= '0;
    end else if (r_state == ST_LATCH) begin
      r_object <= object;
      r_newX   <= newX;
      r_newY   <= newY;
      r_sizeX  <= sizeX;
      r_sizeY  <= sizeY;
      r_col    <= '0;
      r_row    <= '0;
    end else if (w_scan) begin
      if (w_last) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_col_wrap) begin
        r_col <= '0;
        r_row <= r_row + 7'd1;
      end else begin
        r_col <= r_col + 8'd1;
      end
    end
  end

  // busy stays high through the done cycle even though the state is already back in IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_plot   <= 1'b0;
      r_vgaX   <= '0;
      r_vgaY   <= '0;
      r_colour <= BG_COLOUR;
    end else begin
      r_busy <= (w_next != ST_IDLE) || (r_state == ST_DONE);
      r_done <= (r_state == ST_DONE);
      r_plot <= w_scan && w_visible;
      if (w_scan) begin
        r_vgaX   <= w_sum_x[7:0];
        r_vgaY   <= w_sum_y[6:0];
        r_colour <= w_pix_colour;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign plot   = r_plot;
  assign vgaX   = r_vgaX;
  assign vgaY   = r_vgaY;
  assign colour = r_colour;

endmodule

// File: tb/tb_object_plotter.sv
// Directed self-checking bench for object_plotter; expectations follow OBJECT_PLOTTER_ERASE_EN.
module tb_object_plotter;

`ifdef OBJECT_PLOTTER_ERASE_EN
  localparam bit ERASE = 1'b1;
`else
  localparam bit ERASE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       startPlot;
  logic [1:0] object;
  logic [7:0] newX;
  logic [6:0] newY;
  logic [7:0] oldX;
  logic [6:0] oldY;
  logic [7:0] sizeX;
  logic [6:0] sizeY;
  logic       busy;
  logic       done;
  logic [7:0] vgaX;
  logic [6:0] vgaY;
  logic [2:0] colour;
  logic       plot;

  int n_checks = 0;
  int n_fails  = 0;
  int n_plot;
  int n_done;

  always #5 clk = ~clk;

  object_plotter #(
    .MAXX(159),
    .MAXY(119)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .startPlot(startPlot),
    .object   (object),
    .newX     (newX),
    .newY     (newY),
    .oldX     (oldX),
    .oldY     (oldY),
    .sizeX    (sizeX),
    .sizeY    (sizeY),
    .busy     (busy),
    .done     (done),
    .vgaX     (vgaX),
    .vgaY     (vgaY),
    .colour   (colour),
    .plot     (plot)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] colour_of(input logic [1:0] obj);
    case (obj)
      2'b00:   return 3'b111;
      2'b01:   return 3'b010;
      2'b10:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Inputs other than the real request are parked on junk values so a wrong capture edge shows up.
  task automatic set_junk();
    object = 2'b10;
    newX   = 8'd200;
    newY   = 7'd100;
    oldX   = 8'd3;
    oldY   = 7'd3;
    sizeX  = 8'd1;
    sizeY  = 7'd1;
  endtask

  task automatic request(input string name, input logic [1:0] obj,
                         input int nx, input int ny, input int ox, input int oy,
                         input int sx, input int sy, input int exp_pulses,
                         input int drop_k, input bit hold, input bit prearmed,
                         input int abort_k);
    int n, k_done, q, x, y, bx, by;
    bit eplot, in_erase, aborted;
    logic [2:0] ecol;
    aborted = 1'b0;
    n       = (obj == 2'b11) ? 0 : sx * sy;
    k_done  = (ERASE ? 2 * n : n) + 2;
    n_plot  = 0;
    n_done  = 0;
    set_junk();
    if (!prearmed) startPlot = 1'b1;
    @(posedge clk);
    #1;
    object    = obj;
    newX      = 8'(nx);
    newY      = 7'(ny);
    oldX      = 8'(ox);
    oldY      = 7'(oy);
    sizeX     = 8'(sx);
    sizeY     = 7'(sy);
    startPlot = 1'b0;
    @(negedge clk);
    chk($sformatf("%s E0 busy", name), busy, 1);
    chk($sformatf("%s E0 plot", name), plot, 0);
    for (int k = 1; k <= k_done && !aborted; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) set_junk();
      @(negedge clk);
      if (plot === 1'b1) n_plot++;
      if (done === 1'b1) n_done++;
      if (k >= 2 && k < k_done) begin
        q        = k - 2;
        in_erase = ERASE && (q < n);
        if (ERASE && !in_erase) q = q - n;
        bx    = in_erase ? ox : nx;
        by    = in_erase ? oy : ny;
        x     = bx + (q % sx);
        y     = by + (q / sx);
        eplot = (x <= 159) && (y <= 119);
        ecol  = in_erase ? 3'b000 : colour_of(obj);
        chk($sformatf("%s E%0d plot", name, k), plot, eplot);
        if (eplot) begin
          chk($sformatf("%s E%0d vgaX", name, k), vgaX, x);
          chk($sformatf("%s E%0d vgaY", name, k), vgaY, y);
          chk($sformatf("%s E%0d colour", name, k), colour, ecol);
        end
        chk($sformatf("%s E%0d done", name, k), done, 0);
      end else if (k == k_done) begin
        chk($sformatf("%s E%0d done", name, k), done, 1);
        chk($sformatf("%s E%0d plot", name, k), plot, 0);
      end else begin
        chk($sformatf("%s E%0d plot", name, k), plot, 0);
        chk($sformatf("%s E%0d done", name, k), done, 0);
      end
      chk($sformatf("%s E%0d busy", name, k), busy, 1);
      startPlot = (k + 1 == drop_k) || (hold && (k + 1 >= k_done));
      if (k == abort_k) begin
        #2;
        resetn = 1'b0;
        #1;
        chk($sformatf("%s rst plot", name), plot, 0);
        chk($sformatf("%s rst busy", name), busy, 0);
        chk($sformatf("%s rst done", name), done, 0);
        chk($sformatf("%s rst vgaX", name), vgaX, 0);
        chk($sformatf("%s rst vgaY", name), vgaY, 0);
        chk($sformatf("%s rst colour", name), colour, 0);
        aborted = 1'b1;
      end
    end
    if (!aborted) begin
      chk($sformatf("%s pulses", name), n_plot, exp_pulses);
      chk($sformatf("%s done count", name), n_done, 1);
      if (!hold) begin
        @(negedge clk);
        chk($sformatf("%s after busy", name), busy, 0);
        chk($sformatf("%s after done", name), done, 0);
        chk($sformatf("%s after plot", name), plot, 0);
      end
    end
  endtask

  initial begin
    resetn    = 1'b0;
    startPlot = 1'b0;
    set_junk();
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset plot", plot, 0);
    chk("reset vgaX", vgaX, 0);
    chk("reset vgaY", vgaY, 0);
    chk("reset colour", colour, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    request("ball", 2'b00, 11, 21, 10, 20, 4, 4, ERASE ? 32 : 16, 0, 1'b0, 1'b0, 0);
    request("paddle", 2'b01, 150, 115, 140, 100, 20, 1, ERASE ? 30 : 10, 0, 1'b0, 1'b0, 0);
    request("none", 2'b11, 11, 21, 10, 20, 4, 4, 0, 0, 1'b0, 1'b0, 0);
    request("zero", 2'b00, 11, 21, 10, 20, 0, 4, 0, 0, 1'b0, 1'b0, 0);
    // startPlot pulsed at E5 and held from E(2N+2): only the edge after done may start a request.
    request("drop", 2'b00, 11, 21, 10, 20, 4, 4, ERASE ? 32 : 16, 5, 1'b1, 1'b0, 0);
    request("block", 2'b10, 158, 118, 0, 0, 3, 3, ERASE ? 13 : 4, 0, 1'b0, 1'b1, 0);
    request("abort", 2'b00, 11, 21, 10, 20, 4, 4, 0, 0, 1'b0, 1'b0, ERASE ? 21 : 5);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    request("ball2", 2'b00, 11, 21, 10, 20, 4, 4, ERASE ? 32 : 16, 0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
